// File: rtl/reset_sequencer.sv
// Board-level reset sequencer: brings up the PLL, waits for a stable lock, then
// releases staged subsystem resets in order. Handles button, lock-loss and warm resets.
//
// state    | meaning
// PLLRST   | PLL held in reset, all stages held
// WAITLOCK | PLL running, waiting for lock (retries on timeout)
// STABLE   | lock seen, waiting for it to stay high continuously
// RELEASE  | releasing stage resets one by one, bit 0 first
// RUN      | all stages released, ready high
module reset_sequencer #(
  parameter int NUM_STAGES     = 3,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 4194304,
  parameter int STAGE_GAP      = 16,
  parameter int CNT_WIDTH      = 23
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pll_lock,
  input  logic                  ext_req,
  input  logic                  warm_req,
  output logic                  pll_reset,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic                  ready,
  output logic [2:0]            state,
  output logic [7:0]            retry_count,
  output logic [7:0]            loss_count
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [CNT_WIDTH-1:0] T_PLLRST = CNT_WIDTH'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] T_LOCK   = CNT_WIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] T_STABLE = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] T_GAP    = CNT_WIDTH'(STAGE_GAP - 1);

  typedef enum logic [2:0] {
    PLLRST   = 3'd0,
    WAITLOCK = 3'd1,
    STABLE   = 3'd2,
    RELEASE  = 3'd3,
    RUN      = 3'd4
  } state_t;

  state_t                  cur, nxt;
  logic [CNT_WIDTH-1:0]    timer, timer_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic                    retry_inc, loss_inc, stage_step;
  logic                    pll_reset_nxt, ready_nxt;
  logic [NUM_STAGES-1:0]   stage_nxt;
  logic                    lock_meta, lock_s, ext_meta, ext_s;

  // Plain 2-flop synchronizers; left unreset so they track the pins during reset.
  always_ff @(posedge clock) begin
    lock_meta <= pll_lock;
    lock_s    <= lock_meta;
    ext_meta  <= ext_req;
    ext_s     <= ext_meta;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur         <= PLLRST;
      timer       <= '0;
      idx         <= '0;
      pll_reset   <= 1'b1;
      stage_reset <= '1;
      ready       <= 1'b0;
      retry_count <= 8'd0;
      loss_count  <= 8'd0;
    end else begin
      cur         <= nxt;
      timer       <= timer_nxt;
      idx         <= idx_nxt;
      pll_reset   <= pll_reset_nxt;
      stage_reset <= stage_nxt;
      ready       <= ready_nxt;
      if (retry_inc && retry_count != 8'hFF) retry_count <= retry_count + 8'd1;
      if (loss_inc && loss_count != 8'hFF)   loss_count  <= loss_count + 8'd1;
    end
  end

  always_comb begin
    nxt        = cur;
    timer_nxt  = timer + 1'b1;
    idx_nxt    = idx;
    retry_inc  = 1'b0;
    loss_inc   = 1'b0;
    stage_step = 1'b0;
    if (ext_s) begin
      nxt       = PLLRST;
      timer_nxt = '0;
    end else begin
      case (cur)
        PLLRST: begin
          if (timer == T_PLLRST) begin
            nxt       = WAITLOCK;
            timer_nxt = '0;
          end
        end
        WAITLOCK: begin
          if (lock_s) begin
            nxt       = STABLE;
            timer_nxt = '0;
          end else if (timer == T_LOCK) begin
            nxt       = PLLRST;
            timer_nxt = '0;
            retry_inc = 1'b1;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            nxt       = WAITLOCK;
            timer_nxt = '0;
          end else if (timer == T_STABLE) begin
            nxt       = RELEASE;
            timer_nxt = '0;
            idx_nxt   = '0;
          end
        end
        RELEASE: begin
          if (!lock_s) begin
            nxt       = PLLRST;
            timer_nxt = '0;
            loss_inc  = 1'b1;
          end else if (timer == T_GAP) begin
            timer_nxt  = '0;
            stage_step = 1'b1;
            idx_nxt    = idx + 1'b1;
            if (idx == LAST_IDX) nxt = RUN;
          end
        end
        RUN: begin
          // Timer parked at zero here so it can never wrap.
          timer_nxt = '0;
          if (!lock_s) begin
            nxt      = PLLRST;
            loss_inc = 1'b1;
          end else if (warm_req) begin
            nxt = STABLE;
          end
        end
        default: begin
          nxt       = PLLRST;
          timer_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    pll_reset_nxt = (nxt == PLLRST);
    ready_nxt     = (nxt == RUN);
    stage_nxt     = stage_reset;
    if (nxt == PLLRST || nxt == WAITLOCK || nxt == STABLE) begin
      stage_nxt = '1;
    end else if (stage_step) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (idx == IDX_W'(i)) stage_nxt[i] = 1'b0;
      end
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with short timing parameters; expected
// cycle positions are hand-derived from the 2-flop input synchronizer latency.
module tb_reset_sequencer;

  logic       clock;
  logic       reset;
  logic       pll_lock;
  logic       ext_req;
  logic       warm_req;
  logic       pll_reset;
  logic [2:0] stage_reset;
  logic       ready;
  logic [2:0] state;
  logic [7:0] retry_count;
  logic [7:0] loss_count;

  int n_chk = 0;
  int n_bad = 0;

  reset_sequencer #(
    .NUM_STAGES(3), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(32),
    .STABLE_CYCLES(8), .STAGE_GAP(2), .CNT_WIDTH(23)
  ) dut (
    .clock(clock), .reset(reset), .pll_lock(pll_lock), .ext_req(ext_req),
    .warm_req(warm_req), .pll_reset(pll_reset), .stage_reset(stage_reset),
    .ready(ready), .state(state), .retry_count(retry_count), .loss_count(loss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Leaves time just after edge 0, the last edge with reset high.
  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    check("rst_state", state, 0);
    check("rst_pll_reset", pll_reset, 1);
    check("rst_stage", stage_reset, 7);
    check("rst_ready", ready, 0);
    check("rst_retry", retry_count, 0);
    check("rst_loss", loss_count, 0);
  endtask

  initial begin
    reset = 1'b1; pll_lock = 1'b1; ext_req = 1'b0; warm_req = 1'b0;

    // clean bring-up
    do_reset();
    tick(3);  check("clean_pll_hi_e3", pll_reset, 1); check("clean_state_e3", state, 0);
    tick(1);  check("clean_pll_lo_e4", pll_reset, 0); check("clean_state_e4", state, 1);
    tick(1);  check("clean_stable_e5", state, 2);
    tick(8);  check("clean_release_e13", state, 3); check("clean_stage_e13", stage_reset, 7);
    tick(2);  check("clean_stage_e15", stage_reset, 6);
    tick(2);  check("clean_stage_e17", stage_reset, 4); check("clean_ready_e17", ready, 0);
    tick(2);  check("clean_stage_e19", stage_reset, 0); check("clean_ready_e19", ready, 1);
    check("clean_run_e19", state, 4);
    check("clean_retry", retry_count, 0); check("clean_loss", loss_count, 0);

    // lock timeout: lock low for 80 cycles
    pll_lock = 1'b0;
    do_reset();
    tick(36); check("to_state_e36", state, 0); check("to_retry_e36", retry_count, 1);
    check("to_pll_e36", pll_reset, 1);
    tick(3);  check("to_pll_e39", pll_reset, 1);
    tick(1);  check("to_pll_e40", pll_reset, 0); check("to_state_e40", state, 1);
    tick(32); check("to_state_e72", state, 0); check("to_retry_e72", retry_count, 2);
    tick(8);  check("to_state_e80", state, 1);
    pll_lock = 1'b1;
    tick(2);  check("to_state_e82", state, 1);
    tick(1);  check("to_stable_e83", state, 2);
    tick(13); check("to_ready_e96", ready, 0);
    tick(1);  check("to_ready_e97", ready, 1); check("to_stage_e97", stage_reset, 0);
    check("to_retry_final", retry_count, 2);

    // one-cycle lock glitch three cycles into STABLE
    do_reset();
    tick(5);  check("gl_stable_e5", state, 2);
    tick(3);  pll_lock = 1'b0;
    tick(1);  pll_lock = 1'b1;
    tick(1);  check("gl_state_e10", state, 2);
    tick(1);  check("gl_wait_e11", state, 1); check("gl_pll_e11", pll_reset, 0);
    tick(1);  check("gl_stable_e12", state, 2);
    tick(7);  check("gl_stable_e19", state, 2);
    tick(1);  check("gl_release_e20", state, 3);
    tick(6);  check("gl_run_e26", state, 4); check("gl_ready_e26", ready, 1);
    check("gl_loss", loss_count, 0);

    // lock loss in RUN
    pll_lock = 1'b0;
    tick(2);  check("ll_ready_e28", ready, 1);
    tick(1);  check("ll_state_e29", state, 0); check("ll_stage_e29", stage_reset, 7);
    check("ll_ready_e29", ready, 0); check("ll_pll_e29", pll_reset, 1);
    check("ll_loss_e29", loss_count, 1);
    pll_lock = 1'b1;
    tick(4);  check("ll_wait_e33", state, 1);
    tick(1);  check("ll_stable_e34", state, 2);
    tick(13); check("ll_ready_e47", ready, 0);
    tick(1);  check("ll_ready_e48", ready, 1); check("ll_loss_final", loss_count, 1);

    // warm reset from RUN; a pulse in STABLE must be ignored
    warm_req = 1'b1;
    tick(1);  warm_req = 1'b0;
    check("wr_state_e49", state, 2); check("wr_stage_e49", stage_reset, 7);
    check("wr_ready_e49", ready, 0); check("wr_pll_e49", pll_reset, 0);
    tick(2);  warm_req = 1'b1;
    tick(1);  warm_req = 1'b0;
    check("wr_ignored_e52", state, 2);
    tick(10); check("wr_ready_e62", ready, 0);
    tick(1);  check("wr_ready_e63", ready, 1); check("wr_run_e63", state, 4);

    // reset mid-RUN clears loss_count; ext_req held 20 cycles during RELEASE
    do_reset();
    tick(15); check("ext_stage_e15", stage_reset, 6);
    ext_req = 1'b1;
    tick(2);  check("ext_state_e17", state, 3);
    tick(1);  check("ext_state_e18", state, 0); check("ext_stage_e18", stage_reset, 7);
    check("ext_pll_e18", pll_reset, 1); check("ext_ready_e18", ready, 0);
    tick(17); ext_req = 1'b0;
    tick(5);  check("ext_state_e40", state, 0);
    tick(1);  check("ext_state_e41", state, 1); check("ext_pll_e41", pll_reset, 0);
    tick(1);  check("ext_stable_e42", state, 2);
    tick(14); check("ext_run_e56", state, 4); check("ext_ready_e56", ready, 1);
    check("ext_loss", loss_count, 0); check("ext_retry", retry_count, 0);

    // retry_count saturation with lock permanently low
    pll_lock = 1'b0;
    do_reset();
    tick(9179); check("sat_retry_254", retry_count, 254);
    tick(1);    check("sat_retry_255", retry_count, 255);
    tick(100);  check("sat_retry_hold", retry_count, 255); check("sat_state", state, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
